// File: rtl/uart_pkg.sv
// Shared definitions for the UART TX/RX byte-stream arbiters: FSM encoding and
// the header byte format placed in front of each granted packet.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HEADER = 2'd1,
    STREAM = 2'd2
  } tx_state_e;

  localparam logic [3:0] HEADER_TAG = 4'hA;

  function automatic logic [7:0] header_byte(input logic [3:0] id);
    return {HEADER_TAG, id};
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester byte streams, TX FIFO write port and status of the TX arbiter.
// The arbiter uses the slave view; whatever drives requesters/FIFO uses master.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  localparam int IW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]       i_req_valid;
  logic [NUM_REQ-1:0][7:0]  i_req_data;
  logic [NUM_REQ-1:0]       i_req_last;
  logic [NUM_REQ-1:0]       o_req_ready;
  logic                     i_fifo_full;
  logic                     o_fifo_wr_en;
  logic [7:0]               o_fifo_wr_data;
  logic                     o_busy;
  logic [IW-1:0]            o_grant_id;
  logic                     o_len_error;
  logic                     i_err_clear;

  modport slave (
    input  i_req_valid, i_req_data, i_req_last, i_fifo_full, i_err_clear,
    output o_req_ready, o_fifo_wr_en, o_fifo_wr_data, o_busy, o_grant_id, o_len_error
  );

  modport master (
    output i_req_valid, i_req_data, i_req_last, i_fifo_full, i_err_clear,
    input  o_req_ready, o_fifo_wr_en, o_fifo_wr_data, o_busy, o_grant_id, o_len_error
  );
endinterface

// File: rtl/rr_pick.sv
// Round-robin picker: first asserted request at or after 'start', wrapping.
// Purely combinational so the TX and RX arbiters can share it.
module rr_pick #(
  parameter int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [N-1:0]  gnt_oh,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_vld
);

  always_comb begin
    int idx;
    // NOTE: every output gets a default before the loop, otherwise paths that
    // never assign it would infer a latch.
    gnt_oh  = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    idx     = 0;
    for (int i = 0; i < N; i++) begin
      idx = int'(start) + i;
      if (idx >= N) idx = idx - N;
      if (!gnt_vld && req[idx]) begin
        gnt_vld     = 1'b1;
        gnt_idx     = IW'(idx);
        gnt_oh[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Merges NUM_REQ byte-stream requesters into one TX FIFO, one packet per grant,
// optionally prefixed with an ID header byte and capped at MAX_PKT_LEN bytes.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter bit HEADER_EN   = 1'b1,
  parameter int MAX_PKT_LEN = 64
) (
  input logic              clk,
  input logic              rst_n,
  uart_tx_arbiter_if.slave bus
);

  localparam int IW = $clog2(NUM_REQ);

  tx_state_e          state_q, state_d;
  logic [IW-1:0]      grant_q, grant_d;
  logic [NUM_REQ-1:0] grant_oh_q, grant_oh_d;
  logic [IW-1:0]      last_grant_q, last_grant_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               len_err_q, len_err_d;
  logic               busy_q, busy_d;

  logic [IW-1:0]      start_idx;
  logic [NUM_REQ-1:0] pick_oh;
  logic [IW-1:0]      pick_idx;
  logic               pick_vld;

  logic [NUM_REQ-1:0] ready;
  logic               wr_en;
  logic [7:0]         wr_data;
  logic               xfer;
  logic               cnt_hit;

  assign start_idx = (last_grant_q == IW'(NUM_REQ - 1)) ? '0 : last_grant_q + 1'b1;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req     (bus.i_req_valid),
    .start   (start_idx),
    .gnt_oh  (pick_oh),
    .gnt_idx (pick_idx),
    .gnt_vld (pick_vld)
  );

  // Compared in 9 bits so MAX_PKT_LEN=256 is reachable by the 8-bit counter.
  assign cnt_hit = ({1'b0, cnt_q} + 9'd1) == 9'(MAX_PKT_LEN);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      grant_oh_q   <= NUM_REQ'(1);
      last_grant_q <= IW'(NUM_REQ - 1);
      cnt_q        <= '0;
      len_err_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      grant_oh_q   <= grant_oh_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      len_err_q    <= len_err_d;
      busy_q       <= busy_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    grant_oh_d   = grant_oh_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    len_err_d    = len_err_q & ~bus.i_err_clear;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (pick_vld) begin
          grant_d    = pick_idx;
          grant_oh_d = pick_oh;
          state_d    = HEADER_EN ? HEADER : STREAM;
        end
      end
      HEADER: if (!bus.i_fifo_full) state_d = STREAM;
      STREAM: begin
        if (xfer) begin
          cnt_d = cnt_q + 8'd1;
          if (bus.i_req_last[grant_q] || cnt_hit) begin
            state_d      = IDLE;
            last_grant_d = grant_q;
          end
          // A length-error set outranks a simultaneous clear.
          if (!bus.i_req_last[grant_q] && cnt_hit) len_err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_comb begin
    ready   = '0;
    wr_en   = 1'b0;
    wr_data = '0;
    xfer    = 1'b0;
    unique case (state_q)
      HEADER: begin
        wr_en   = !bus.i_fifo_full;
        wr_data = header_byte(4'(grant_q));
      end
      STREAM: begin
        ready   = bus.i_fifo_full ? '0 : grant_oh_q;
        wr_en   = bus.i_req_valid[grant_q] && !bus.i_fifo_full;
        wr_data = bus.i_req_data[grant_q];
        xfer    = wr_en;
      end
      default: ;
    endcase
  end

  assign bus.o_req_ready    = ready;
  assign bus.o_fifo_wr_en   = wr_en;
  assign bus.o_fifo_wr_data = wr_data;
  assign bus.o_busy         = busy_q;
  assign bus.o_grant_id     = grant_q;
  assign bus.o_len_error    = len_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed and randomized checks of uart_tx_arbiter against a packet-level
// model: round-robin over pending requesters, header, then up to MAX bytes.
module tb_uart_tx_arbiter;

  localparam int NR   = 4;
  localparam int MAXL = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  uart_tx_arbiter_if #(.NUM_REQ(NR)) bus ();
  uart_tx_arbiter_if #(.NUM_REQ(NR)) bus_nh ();

  logic [NR-1:0]      drv_valid, drv_last;
  logic [NR-1:0][7:0] drv_data;
  logic               drv_full, drv_err_clear, use_nh;

  assign bus.i_req_valid    = use_nh ? '0 : drv_valid;
  assign bus.i_req_data     = drv_data;
  assign bus.i_req_last     = drv_last;
  assign bus.i_fifo_full    = drv_full;
  assign bus.i_err_clear    = drv_err_clear;
  assign bus_nh.i_req_valid = use_nh ? drv_valid : '0;
  assign bus_nh.i_req_data  = drv_data;
  assign bus_nh.i_req_last  = drv_last;
  assign bus_nh.i_fifo_full = drv_full;
  assign bus_nh.i_err_clear = drv_err_clear;

  wire [NR-1:0] o_ready   = use_nh ? bus_nh.o_req_ready    : bus.o_req_ready;
  wire          o_wr_en   = use_nh ? bus_nh.o_fifo_wr_en   : bus.o_fifo_wr_en;
  wire [7:0]    o_wr_data = use_nh ? bus_nh.o_fifo_wr_data : bus.o_fifo_wr_data;
  wire          o_busy    = use_nh ? bus_nh.o_busy         : bus.o_busy;
  wire [1:0]    o_grant   = use_nh ? bus_nh.o_grant_id     : bus.o_grant_id;
  wire          o_len_err = use_nh ? bus_nh.o_len_error    : bus.o_len_error;

  uart_tx_arbiter #(.NUM_REQ(NR), .HEADER_EN(1'b1), .MAX_PKT_LEN(MAXL)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  uart_tx_arbiter #(.NUM_REQ(NR), .HEADER_EN(1'b0), .MAX_PKT_LEN(64)) u_dut_nh (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_nh)
  );

  // Per-requester pending bytes: bit 8 is the last flag.
  logic [8:0] rq [NR][$];
  logic [8:0] mq [NR][$];
  logic [7:0] obs [$];
  int         obs_cyc [$];
  logic [7:0] exp_q [$];
  logic [8:0] b;
  int         lg, g, n;
  bit         exp_err, any;

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, o, e);
    end
  endtask

  task automatic compare_obs(input string tag);
    check({tag, "_count"}, obs.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++)
      check($sformatf("%s[%0d]", tag, i), obs[i], exp_q[i]);
  endtask

  task automatic do_reset();
    drv_valid = '0; drv_last = '0; drv_data = '0;
    drv_full = 1'b0; drv_err_clear = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic push_byte(input int r, input logic [7:0] d, input bit last);
    rq[r].push_back({last, d});
  endtask

  // Drives every requester from its queue; full_mode 0=never, 1=random, 2=window.
  task automatic run_traffic(input int max_cycles, input int full_mode, input int lo, input int hi);
    int  cyc   = 0;
    int  quiet = 0;
    bit  done  = 0;
    bit  pend;
    obs.delete();
    obs_cyc.delete();
    while (!done && cyc < max_cycles) begin
      @(negedge clk);
      for (int r = 0; r < NR; r++) begin
        drv_valid[r] = rq[r].size() > 0;
        drv_data[r]  = drv_valid[r] ? rq[r][0][7:0] : 8'h00;
        drv_last[r]  = drv_valid[r] ? rq[r][0][8] : 1'b0;
      end
      case (full_mode)
        1:       drv_full = ($urandom_range(0, 3) == 0);
        2:       drv_full = (cyc >= lo && cyc <= hi);
        default: drv_full = 1'b0;
      endcase
      #1;
      if (o_wr_en) begin
        obs.push_back(o_wr_data);
        obs_cyc.push_back(cyc);
      end
      if (drv_full) begin
        check("wr_en_while_full", o_wr_en, 0);
        check("ready_while_full", o_ready, 0);
      end
      if (o_ready != 0) check("ready_onehot", $countones(o_ready), 1);
      pend = 0;
      for (int r = 0; r < NR; r++) begin
        if (drv_valid[r] && o_ready[r]) void'(rq[r].pop_front());
        if (rq[r].size() > 0) pend = 1;
      end
      quiet = pend ? 0 : quiet + 1;
      if (!pend && (!o_busy || quiet >= 4)) done = 1;
      cyc++;
    end
    check("traffic_done", done, 1);
  endtask

  initial begin
    use_nh = 1'b0;
    drv_valid = '0; drv_last = '0; drv_data = '0;
    drv_full = 1'b0; drv_err_clear = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy", bus.o_busy, 0);
    check("rst_wr_en", bus.o_fifo_wr_en, 0);
    check("rst_ready", bus.o_req_ready, 0);
    check("rst_grant", bus.o_grant_id, 0);
    check("rst_len_err", bus.o_len_error, 0);
    check("rst_nh_busy", bus_nh.o_busy, 0);
    rst_n = 1'b1;

    // Single packet from requester 1.
    do_reset();
    push_byte(1, 8'h11, 0); push_byte(1, 8'h22, 0); push_byte(1, 8'h33, 1);
    run_traffic(50, 0, 0, 0);
    exp_q.delete();
    exp_q.push_back(8'hA1); exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
    compare_obs("single");
    for (int i = 1; i < obs_cyc.size(); i++)
      check($sformatf("single_consec[%0d]", i), obs_cyc[i], obs_cyc[0] + i);
    check("single_busy_end", o_busy, 0);

    // Fairness: all requesters continuously valid with 1-byte packets.
    do_reset();
    exp_q.delete();
    for (int p = 0; p < 2; p++)
      for (int r = 0; r < NR; r++) begin
        push_byte(r, 8'(8'h40 + 16 * p + r), 1);
        exp_q.push_back(8'(8'hA0 + r));
        exp_q.push_back(8'(8'h40 + 16 * p + r));
      end
    run_traffic(100, 0, 0, 0);
    compare_obs("fair");

    // Backpressure mid-packet; packet is exactly MAX bytes with last.
    do_reset();
    exp_q.delete();
    exp_q.push_back(8'hA0);
    for (int i = 0; i < 4; i++) begin
      push_byte(0, 8'(8'hC0 + i), i == 3);
      exp_q.push_back(8'(8'hC0 + i));
    end
    run_traffic(60, 2, 3, 7);
    compare_obs("bp");
    check("bp_len_err", o_len_err, 0);

    // Overlength: 6 bytes, no last, MAX=4.
    do_reset();
    exp_q.delete();
    exp_q.push_back(8'hA2);
    for (int i = 0; i < 6; i++) begin
      push_byte(2, 8'(8'hD0 + i), 0);
      if (i == 4) exp_q.push_back(8'hA2);
      exp_q.push_back(8'(8'hD0 + i));
    end
    run_traffic(60, 0, 0, 0);
    compare_obs("ovl");
    check("ovl_len_err", o_len_err, 1);
    check("ovl_busy", o_busy, 1);
    check("ovl_grant", o_grant, 2);
    @(negedge clk); drv_err_clear = 1'b1;
    @(negedge clk); drv_err_clear = 1'b0;
    #1 check("ovl_err_cleared", o_len_err, 0);
    // Two more bytes reach MAX again while a clear is applied: the set wins.
    @(negedge clk); drv_valid = 4'b0100; drv_data[2] = 8'h77; drv_last = '0;
    #1 check("setwin_wr0", o_wr_en, 1); check("setwin_d0", o_wr_data, 8'h77);
    @(negedge clk); drv_data[2] = 8'h88; drv_err_clear = 1'b1;
    #1 check("setwin_wr1", o_wr_en, 1);
    @(negedge clk); drv_valid = '0; drv_err_clear = 1'b0;
    #1 check("setwin_len_err", o_len_err, 1); check("setwin_busy", o_busy, 0);

    // Asynchronous reset in the middle of the payload.
    do_reset();
    @(negedge clk); drv_valid = 4'b0100; drv_data[2] = 8'h51; drv_last = '0;
    @(negedge clk); #1 check("arst_hdr", o_wr_data, 8'hA2);
    @(negedge clk); #1 check("arst_b0", o_wr_data, 8'h51);
    @(negedge clk); drv_data[2] = 8'h52;
    #1 check("arst_b1_wr", o_wr_en, 1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_wr_en", o_wr_en, 0);
    check("arst_ready", o_ready, 0);
    check("arst_busy", o_busy, 0);
    check("arst_grant", o_grant, 0);
    @(negedge clk);
    drv_valid = 4'b1001; drv_last = 4'b1001; drv_data[0] = 8'h60; drv_data[3] = 8'h63;
    rst_n = 1'b1;
    @(negedge clk); #1;
    check("arst_restart_grant", o_grant, 0);
    check("arst_restart_hdr", o_wr_data, 8'hA0);

    // Header disabled.
    use_nh = 1'b1;
    do_reset();
    push_byte(1, 8'h11, 0); push_byte(1, 8'h22, 0); push_byte(1, 8'h33, 1);
    run_traffic(50, 0, 0, 0);
    exp_q.delete();
    exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
    compare_obs("nohdr");
    use_nh = 1'b0;

    // Randomized traffic against the packet-level model.
    for (int round = 0; round < 3; round++) begin
      do_reset();
      for (int r = 0; r < NR; r++)
        for (int p = 0; p < 3; p++) begin
          n = $urandom_range(1, 7);
          for (int k = 0; k < n; k++) push_byte(r, 8'($urandom), k == n - 1);
        end
      for (int r = 0; r < NR; r++) mq[r] = rq[r];
      exp_q.delete();
      lg = NR - 1;
      exp_err = 0;
      any = 1;
      while (any) begin
        g = -1;
        for (int k = 1; k <= NR; k++)
          if (g < 0 && mq[(lg + k) % NR].size() > 0) g = (lg + k) % NR;
        exp_q.push_back(8'(8'hA0 + g));
        n = 0;
        while (mq[g].size() > 0) begin
          b = mq[g].pop_front();
          exp_q.push_back(b[7:0]);
          n++;
          if (b[8]) break;
          if (n == MAXL) begin
            exp_err = 1;
            break;
          end
        end
        lg = g;
        any = 0;
        for (int r = 0; r < NR; r++) if (mq[r].size() > 0) any = 1;
      end
      run_traffic(3000, 1, 0, 0);
      compare_obs($sformatf("rand%0d", round));
      check($sformatf("rand%0d_len_err", round), o_len_err, 32'(exp_err));
      check($sformatf("rand%0d_grant", round), o_grant, 32'(lg));
      check($sformatf("rand%0d_busy", round), o_busy, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of byte-stream requesters (legal range 2..16).
REQ-002 SHALL have parameter HEADER_EN, default 1'b1, which prefixes each packet with an ID header byte.
REQ-003 SHALL have parameter MAX_PKT_LEN, default 64, the maximum number of payload bytes per grant (legal range 2..256).
REQ-004 SHALL have port clk  input  1  single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port i_req_valid  input  NUM_REQ  per-requester byte valid.
REQ-007 SHALL have port i_req_data  input  NUM_REQ x 8  per-requester byte.
REQ-008 SHALL have port i_req_last  input  NUM_REQ  marks the final byte of a packet.
REQ-009 SHALL have port o_req_ready  output  NUM_REQ  per-requester byte accept.
REQ-010 SHALL have port i_fifo_full  input  1  from the TX FIFO full flag.
REQ-011 SHALL have port o_fifo_wr_en  output  1  TX FIFO write enable.
REQ-012 SHALL have port o_fifo_wr_data  output  8  TX FIFO write data.
REQ-013 SHALL have port o_busy  output  1  high whenever state != IDLE.
REQ-014 SHALL have port o_grant_id  output  $clog2(NUM_REQ)  current or most recent grantee.
REQ-015 SHALL have port o_len_error  output  1  sticky flag, set when a packet exceeds MAX_PKT_LEN.
REQ-016 SHALL have port i_err_clear  input  1  clears o_len_error.

Function
REQ-017 SHALL implement the FSM states IDLE, HEADER and STREAM, held in a registered state.
REQ-018 IDLE: if any i_req_valid is high, the FSM SHALL select a grantee round-robin, searching from last_grant+1 with wrap, latch it into o_grant_id, and go to HEADER (HEADER_EN=1) or STREAM (HEADER_EN=0). It SHALL issue no write in IDLE.
REQ-019 The minimum arbitration latency SHALL be one cycle in IDLE, i.e. one idle cycle between packets.
REQ-020 HEADER: o_fifo_wr_en SHALL equal !i_fifo_full and o_fifo_wr_data SHALL be {4'hA, grant_id zero-extended to 4 bits}. The FSM SHALL go to STREAM on the write cycle and hold while full.
REQ-021 STREAM: o_req_ready[g] SHALL equal !i_fifo_full; all other ready bits SHALL be 0.
REQ-022 STREAM: a transfer SHALL be valid[g] && ready[g]. On a transfer, o_fifo_wr_en=1 and o_fifo_wr_data=i_req_data[g] in the same cycle, so the path is combinational with zero latency.
REQ-023 o_fifo_wr_en SHALL never be high while i_fifo_full is high.
REQ-024 STREAM: if valid[g] is low, the grant SHALL hold, with no write and no timeout.
REQ-025 An 8-bit payload counter SHALL clear on entry to STREAM and increment on each transfer.
REQ-026 A transfer with i_req_last=1 SHALL return the FSM to IDLE and set last_grant=g.
REQ-027 A transfer without last that makes the count reach MAX_PKT_LEN SHALL force IDLE, set last_grant=g and set o_len_error. The requester's next byte then starts a new arbitration.
REQ-028 o_len_error: a set in the same cycle as i_err_clear SHALL win.
REQ-029 Requesters other than the grantee SHALL see ready=0 for the whole grant, including HEADER.
REQ-030 All outputs except the wr_en/wr_data/ready combinational terms SHALL be registered. Those combinational terms SHALL depend only on the registered state, grant, i_fifo_full, i_req_valid and i_req_data.
REQ-031 Requester inputs SHALL be assumed AXI-stream-like: once valid is high, data and last are stable until the transfer; this is not checked.

Reset
REQ-032 While rst_n is low: state=IDLE, o_grant_id=0, last_grant=NUM_REQ-1 (first search starts at requester 0), counter=0, o_len_error=0, o_busy=0, o_fifo_wr_en=0, o_req_ready=0.
REQ-033 Reset asserted mid-packet SHALL abort immediately. The partial packet remains in the FIFO; clearing it is the owner's responsibility via the FIFO clear.

Structure
REQ-034 The state enum (IDLE/HEADER/STREAM) and the HEADER_TAG constant 4'hA SHALL live in the shared package uart_pkg.
REQ-035 The round-robin pick logic SHALL be one sub-module, rr_pick (NUM_REQ requests, start pointer -> one-hot grant plus index), reusable by the RX side.

Verification
REQ-036 Single packet: req1 sends 3 bytes 0x11,0x22,0x33 with last on 0x33, fifo never full -> FIFO gets 0xA1,0x11,0x22,0x33 on 4 consecutive cycles, then o_busy=0.
REQ-037 Fairness: all 4 requesters continuously valid with 1-byte packets -> grant order 0,1,2,3,0,1...; headers 0xA0,0xA1,0xA2,0xA3.
REQ-038 Backpressure: i_fifo_full high for 5 cycles mid-packet -> no wr_en and ready=0 during those cycles, no byte lost or duplicated, order preserved.
REQ-039 Overlength: MAX_PKT_LEN=4, req2 sends 6 bytes with no last -> 4 payload bytes written, o_len_error=1, a new header 0xA2 is written (if no other requester) followed by the remaining 2 bytes; i_err_clear -> o_len_error=0.
REQ-040 Reset mid-STREAM: rst_n low during byte 2 -> wr_en=0 and ready=0 in the same cycle (asynchronous); after release, round-robin restarts at requester 0.
REQ-041 HEADER_EN=0: same stimulus as REQ-036 -> FIFO gets exactly 0x11,0x22,0x33.
